// File: rtl/aeolus_control_sequencer.sv
// Aeolus instruction decoder/sequencer: accepts one instruction per handshake and
// steps it through DECODE, EXEC (ALU ops only) and WB, driving datapath strobes.
module aeolus_control_sequencer #(
  parameter int ALU_LAT = 1,
  parameter int OPC_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [7:0] instr,
  input  logic       alu_overflow,
  output logic [3:0] imm,
  output logic       lda,
  output logic       ldb,
  output logic       alu_add,
  output logic       alu_sub,
  output logic       alu_lshift,
  output logic       alu_rshift,
  output logic       in1_sel,
  output logic       ld_acc,
  output logic       clr_acc,
  output logic       ld_o,
  output logic       done,
  output logic       halted,
  output logic       illegal,
  output logic       ovf_flag
);

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, WB, HALTED} state_t;

  localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_LDA  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_LDB  = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_LSL  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_LSR  = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_OUT  = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_CLR  = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(15);

  localparam logic [2:0] EXEC_LAST = 3'(ALU_LAT - 1);

  state_t           state;
  logic [OPC_W-1:0] opcode;
  logic [2:0]       exec_cnt;

  assign instr_ready = (state == IDLE);
  assign halted      = (state == HALTED);

  // Strobes default low every edge and are raised only on the edge entering WB,
  // so each one lasts exactly the single WB cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      opcode     <= '0;
      exec_cnt   <= '0;
      imm        <= '0;
      lda        <= 1'b0;
      ldb        <= 1'b0;
      alu_add    <= 1'b0;
      alu_sub    <= 1'b0;
      alu_lshift <= 1'b0;
      alu_rshift <= 1'b0;
      in1_sel    <= 1'b0;
      ld_acc     <= 1'b0;
      clr_acc    <= 1'b0;
      ld_o       <= 1'b0;
      done       <= 1'b0;
      illegal    <= 1'b0;
      ovf_flag   <= 1'b0;
    end else begin
      lda     <= 1'b0;
      ldb     <= 1'b0;
      ld_acc  <= 1'b0;
      clr_acc <= 1'b0;
      ld_o    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;

      case (state)
        IDLE: begin
          if (instr_valid) begin
            opcode <= instr[7 -: OPC_W];
            imm    <= instr[3:0];
            state  <= DECODE;
          end
        end

        DECODE: begin
          exec_cnt <= '0;
          case (opcode)
            OP_ADD: begin alu_add <= 1'b1; state <= EXEC; end
            OP_SUB: begin alu_sub <= 1'b1; state <= EXEC; end
            OP_LSL: begin alu_lshift <= 1'b1; in1_sel <= 1'b1; state <= EXEC; end
            OP_LSR: begin alu_rshift <= 1'b1; in1_sel <= 1'b1; state <= EXEC; end
            OP_HALT: state <= HALTED;
            default: begin
              state <= WB;
              done  <= 1'b1;
              case (opcode)
                OP_NOP: ;
                OP_LDA: lda     <= 1'b1;
                OP_LDB: ldb     <= 1'b1;
                OP_OUT: ld_o    <= 1'b1;
                OP_CLR: clr_acc <= 1'b1;
                default: illegal <= 1'b1;
              endcase
            end
          endcase
        end

        EXEC: begin
          if (exec_cnt == EXEC_LAST) begin
            state  <= WB;
            ld_acc <= 1'b1;
            done   <= 1'b1;
          end else begin
            exec_cnt <= exec_cnt + 3'd1;
          end
        end

        // Op selects were held through WB; overflow is sampled at the end of it.
        WB: begin
          state      <= IDLE;
          alu_add    <= 1'b0;
          alu_sub    <= 1'b0;
          alu_lshift <= 1'b0;
          alu_rshift <= 1'b0;
          in1_sel    <= 1'b0;
          if (opcode == OP_ADD || opcode == OP_SUB)
            ovf_flag <= ovf_flag | alu_overflow;
          else if (opcode == OP_CLR)
            ovf_flag <= 1'b0;
        end

        HALTED: state <= HALTED;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aeolus_control_sequencer.sv
// Directed self-checking bench for aeolus_control_sequencer (ALU_LAT=1).
module tb_aeolus_control_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr;
  logic       alu_overflow;
  logic [3:0] imm;
  logic       lda, ldb, alu_add, alu_sub, alu_lshift, alu_rshift, in1_sel;
  logic       ld_acc, clr_acc, ld_o, done, halted, illegal, ovf_flag;

  int tests_run = 0;
  int tests_failed = 0;

  logic [4:0] strobes;
  logic [3:0] alu_sel;
  assign strobes = {lda, ldb, ld_acc, clr_acc, ld_o};
  assign alu_sel = {alu_add, alu_sub, alu_lshift, alu_rshift};

  aeolus_control_sequencer #(.ALU_LAT(1), .OPC_W(4)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_overflow(alu_overflow), .imm(imm), .lda(lda), .ldb(ldb),
    .alu_add(alu_add), .alu_sub(alu_sub), .alu_lshift(alu_lshift), .alu_rshift(alu_rshift),
    .in1_sel(in1_sel), .ld_acc(ld_acc), .clr_acc(clr_acc), .ld_o(ld_o), .done(done),
    .halted(halted), .illegal(illegal), .ovf_flag(ovf_flag)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one instruction for a single accept edge; returns just after that edge.
  task automatic applyStimulus(input logic [7:0] ins);
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = ins;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = 8'h00;
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  // Checks a non-ALU instruction: WB is the second cycle after accept.
  task automatic checkSimple(input string tag, input logic [7:0] ins, input logic [4:0] exp_strobes,
                             input logic exp_illegal);
    applyStimulus(ins);
    nextCycle();
    checkOutput({tag, "_c1_done"}, done, 0);
    checkOutput({tag, "_c1_ready"}, instr_ready, 0);
    nextCycle();
    checkOutput({tag, "_wb_strobes"}, strobes, exp_strobes);
    checkOutput({tag, "_wb_done"}, done, 1);
    checkOutput({tag, "_wb_illegal"}, illegal, exp_illegal);
    checkOutput({tag, "_wb_alu"}, alu_sel, 0);
    checkOutput({tag, "_wb_imm"}, imm, ins[3:0]);
    nextCycle();
    checkOutput({tag, "_after_strobes"}, strobes, 0);
    checkOutput({tag, "_after_done"}, {done, illegal}, 0);
    checkOutput({tag, "_after_ready"}, instr_ready, 1);
  endtask

  // Checks an ALU instruction: EXEC one cycle, WB the third cycle after accept.
  task automatic checkAlu(input string tag, input logic [7:0] ins, input logic [3:0] exp_alu,
                          input logic exp_in1);
    applyStimulus(ins);
    nextCycle();
    checkOutput({tag, "_dec_alu"}, alu_sel, 0);
    nextCycle();
    checkOutput({tag, "_exec_alu"}, alu_sel, exp_alu);
    checkOutput({tag, "_exec_in1"}, in1_sel, exp_in1);
    checkOutput({tag, "_exec_done"}, {done, ld_acc}, 0);
    nextCycle();
    checkOutput({tag, "_wb_alu"}, alu_sel, exp_alu);
    checkOutput({tag, "_wb_in1"}, in1_sel, exp_in1);
    checkOutput({tag, "_wb_strobes"}, strobes, 5'b00100);
    checkOutput({tag, "_wb_done"}, done, 1);
    nextCycle();
    checkOutput({tag, "_after_alu"}, alu_sel, 0);
    checkOutput({tag, "_after_in1"}, in1_sel, 0);
    checkOutput({tag, "_after_ready"}, instr_ready, 1);
  endtask

  initial begin
    int lda_seen;
    int done_seen;
    reset        = 1'b1;
    instr_valid  = 1'b0;
    instr        = 8'h00;
    alu_overflow = 1'b0;
    repeat (2) nextCycle();
    checkOutput("reset_ready", instr_ready, 1);
    checkOutput("reset_strobes", {strobes, alu_sel, in1_sel}, 0);
    checkOutput("reset_flags", {done, halted, illegal, ovf_flag}, 0);
    checkOutput("reset_imm", imm, 0);
    reset = 1'b0;

    // Reset asserted mid-EXEC of ADD clears everything immediately.
    applyStimulus(8'h30);
    nextCycle();
    nextCycle();
    checkOutput("rst_exec_alu_before", alu_sel, 4'b1000);
    #1 reset = 1'b1;
    #1;
    checkOutput("rst_exec_alu", alu_sel, 0);
    checkOutput("rst_exec_strobes", {strobes, in1_sel, done}, 0);
    nextCycle();
    reset = 1'b0;
    nextCycle();
    checkOutput("rst_release_ready", instr_ready, 1);
    checkOutput("rst_release_strobes", {strobes, alu_sel, done}, 0);

    checkSimple("lda", 8'h15, 5'b10000, 1'b0);
    checkSimple("ldb", 8'h2A, 5'b01000, 1'b0);

    alu_overflow = 1'b1;
    checkAlu("add_ovf", 8'h30, 4'b1000, 1'b0);
    alu_overflow = 1'b0;
    checkOutput("ovf_set", ovf_flag, 1);
    checkAlu("sub", 8'h40, 4'b0100, 1'b0);
    checkOutput("ovf_sticky", ovf_flag, 1);
    checkSimple("clr", 8'h80, 5'b00010, 1'b0);
    checkOutput("ovf_cleared", ovf_flag, 0);

    checkAlu("lsl", 8'h50, 4'b0010, 1'b1);
    checkAlu("lsr", 8'h60, 4'b0001, 1'b1);
    checkSimple("out", 8'h77, 5'b00001, 1'b0);
    checkSimple("illegal", 8'hA0, 5'b00000, 1'b1);
    checkSimple("illegal_e", 8'hE3, 5'b00000, 1'b1);
    checkSimple("nop", 8'h09, 5'b00000, 1'b0);
    checkOutput("ovf_untouched", ovf_flag, 0);

    // HALT, then an LDA held valid must never be taken.
    applyStimulus(8'hF0);
    instr_valid = 1'b1;
    instr       = 8'h15;
    lda_seen    = 0;
    done_seen   = 0;
    for (int i = 0; i < 10; i++) begin
      nextCycle();
      if (lda) lda_seen++;
      if (done) done_seen++;
    end
    checkOutput("halt_halted", halted, 1);
    checkOutput("halt_ready", instr_ready, 0);
    checkOutput("halt_lda_pulses", lda_seen, 0);
    checkOutput("halt_done_pulses", done_seen, 0);
    checkOutput("halt_strobes", {strobes, alu_sel}, 0);
    instr_valid = 1'b0;
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    nextCycle();
    checkOutput("halt_reset_exit", {halted, instr_ready}, 2'b01);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
